// File: rtl/exu_bju_seq.sv
// Sequential branch/jump unit: accepts one op, runs compare/add on the shared calculator,
// then holds a registered redirect/result for writeback while maintaining a return-address stack.
module exu_bju_seq #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            hs_ex4bj_val,
  output logic            hs_bj4ex_rdy,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_opn1,
  input  logic [XLEN-1:0] i_opn2,
  input  logic [XLEN-1:0] i_im,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_rd_link,
  input  logic            i_rs1_link,
  input  logic            i_int_ena,
  input  logic [XLEN-1:0] i_mepc,
  input  logic [XLEN-1:0] i_mtvec,
  output logic            hs_bj4cal_val,
  input  logic            hs_cal4bj_rdy,
  output logic [2:0]      o_cal_op,
  output logic [XLEN:0]   o_cal_opn1,
  output logic [XLEN:0]   o_cal_opn2,
  input  logic [XLEN-1:0] i_cal_res,
  output logic            hs_bj4wb_val,
  input  logic            hs_wb4bj_rdy,
  output logic [XLEN-1:0] o_res,
  output logic            o_setpc,
  output logic [XLEN-1:0] o_pc,
  output logic            o_misalign,
  output logic            o_mret,
  output logic [XLEN-1:0] o_ras_top,
  output logic            o_ras_vld
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] OP_BEQ   = 4'd0;
  localparam logic [3:0] OP_BNE   = 4'd1;
  localparam logic [3:0] OP_BLT   = 4'd2;
  localparam logic [3:0] OP_BGE   = 4'd3;
  localparam logic [3:0] OP_BLTU  = 4'd4;
  localparam logic [3:0] OP_BGEU  = 4'd5;
  localparam logic [3:0] OP_JAL   = 4'd6;
  localparam logic [3:0] OP_JALR  = 4'd7;
  localparam logic [3:0] OP_AUIPC = 4'd8;
  localparam logic [3:0] OP_MRET  = 4'd9;

  localparam logic [2:0] CAL_ADD = 3'b100;
  localparam logic [2:0] CAL_CMP = 3'b010;
  localparam logic [2:0] CAL_XOR = 3'b001;
  localparam logic [XLEN:0] PC_STEP = {{(XLEN-2){1'b0}}, 3'b100};

  typedef enum logic [1:0] {IDLE, CAL, RESP} state_t;
  state_t state, state_nxt;

  logic [3:0]      op_q;
  logic [XLEN-1:0] opn1_q, opn2_q, im_q, pc_q, mepc_q, mtvec_q, res_q;
  logic            rd_link_q, rs1_link_q, int_q;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr, ras_top_idx;
  logic [CW-1:0]   ras_cnt;
  logic            ras_push, ras_pop, ras_repl;

  logic accept, cal_done, wb_fire, skip_cal, in_resp;

  assign accept   = (state == IDLE) & hs_ex4bj_val & ~i_flush;
  assign cal_done = (state == CAL) & hs_cal4bj_rdy & ~i_flush;
  assign wb_fire  = (state == RESP) & hs_wb4bj_rdy & ~i_flush;
  assign in_resp  = (state == RESP);
  // Interrupts, MRET and NOPs need no calculator work
  assign skip_cal = i_int_ena | (i_op >= OP_MRET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = skip_cal ? RESP : CAL;
      CAL:     if (i_flush) state_nxt = IDLE;
               else if (hs_cal4bj_rdy) state_nxt = RESP;
      RESP:    if (i_flush | hs_wb4bj_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      opn1_q     <= '0;
      opn2_q     <= '0;
      im_q       <= '0;
      pc_q       <= '0;
      mepc_q     <= '0;
      mtvec_q    <= '0;
      res_q      <= '0;
      rd_link_q  <= 1'b0;
      rs1_link_q <= 1'b0;
      int_q      <= 1'b0;
    end else if (accept) begin
      op_q       <= i_op;
      opn1_q     <= i_opn1;
      opn2_q     <= i_opn2;
      im_q       <= i_im;
      pc_q       <= i_pc;
      mepc_q     <= i_mepc;
      mtvec_q    <= i_mtvec;
      res_q      <= '0;
      rd_link_q  <= i_rd_link;
      rs1_link_q <= i_rs1_link;
      int_q      <= i_int_ena;
    end else if (cal_done) begin
      res_q      <= i_cal_res;
    end
  end

  logic [2:0]    cal_op;
  logic [XLEN:0] cal_a, cal_b;

  always_comb begin
    cal_op = '0;
    cal_a  = '0;
    cal_b  = '0;
    case (op_q)
      OP_BEQ, OP_BNE: begin
        cal_op = CAL_XOR;
        cal_a  = {opn1_q[XLEN-1], opn1_q};
        cal_b  = {opn2_q[XLEN-1], opn2_q};
      end
      OP_BLT, OP_BGE: begin
        cal_op = CAL_CMP;
        cal_a  = {opn1_q[XLEN-1], opn1_q};
        cal_b  = {opn2_q[XLEN-1], opn2_q};
      end
      OP_BLTU, OP_BGEU: begin
        cal_op = CAL_CMP;
        cal_a  = {1'b0, opn1_q};
        cal_b  = {1'b0, opn2_q};
      end
      OP_JAL, OP_JALR: begin
        cal_op = CAL_ADD;
        cal_a  = {1'b0, pc_q};
        cal_b  = PC_STEP;
      end
      OP_AUIPC: begin
        cal_op = CAL_ADD;
        cal_a  = {1'b0, pc_q};
        cal_b  = {1'b0, im_q};
      end
      default: ;
    endcase
  end

  assign hs_bj4cal_val = (state == CAL);
  assign o_cal_op      = hs_bj4cal_val ? cal_op : '0;
  assign o_cal_opn1    = hs_bj4cal_val ? cal_a : '0;
  assign o_cal_opn2    = hs_bj4cal_val ? cal_b : '0;

  logic            setpc, any_res;
  logic [XLEN-1:0] tgt, wb_res, jalr_sum;

  assign any_res  = |res_q;
  assign jalr_sum = opn1_q + im_q;

  // Interrupt redirect overrides whatever op was accepted alongside it
  always_comb begin
    setpc  = 1'b0;
    tgt    = '0;
    wb_res = '0;
    if (int_q) begin
      setpc = 1'b1;
      tgt   = mtvec_q;
    end else begin
      case (op_q)
        OP_BEQ, OP_BGE, OP_BGEU: begin setpc = ~any_res; tgt = pc_q + im_q; end
        OP_BNE, OP_BLT, OP_BLTU: begin setpc = any_res;  tgt = pc_q + im_q; end
        OP_JAL:   begin setpc = 1'b1; tgt = pc_q + im_q; wb_res = res_q; end
        OP_JALR:  begin setpc = 1'b1; tgt = {jalr_sum[XLEN-1:1], 1'b0}; wb_res = res_q; end
        OP_AUIPC: wb_res = res_q;
        OP_MRET:  begin setpc = 1'b1; tgt = mepc_q; end
        default: ;
      endcase
    end
  end

  assign hs_bj4ex_rdy = (state == IDLE);
  assign hs_bj4wb_val = in_resp;
  assign o_setpc      = in_resp & setpc;
  assign o_pc         = in_resp ? tgt : '0;
  assign o_res        = in_resp ? wb_res : '0;
  assign o_misalign   = o_setpc & o_pc[1];
  assign o_mret       = wb_fire & (op_q == OP_MRET) & ~int_q;

  assign ras_top_idx = ras_ptr - PW'(1);

  // JALR with both link bits is a coroutine swap: replace the top, or push if empty
  always_comb begin
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ras_repl = 1'b0;
    if (wb_fire & ~int_q) begin
      if (op_q == OP_JAL) begin
        ras_push = rd_link_q;
      end else if (op_q == OP_JALR) begin
        if (rd_link_q & rs1_link_q) begin
          ras_repl = (ras_cnt != '0);
          ras_push = (ras_cnt == '0);
        end else begin
          ras_push = rd_link_q;
          ras_pop  = rs1_link_q & (ras_cnt != '0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (ras_push) begin
      ras_mem[ras_ptr] <= res_q;
      ras_ptr          <= ras_ptr + PW'(1);
      if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + CW'(1);
    end else if (ras_repl) begin
      ras_mem[ras_top_idx] <= res_q;
    end else if (ras_pop) begin
      ras_ptr <= ras_top_idx;
      ras_cnt <= ras_cnt - CW'(1);
    end
  end

  assign o_ras_vld = (ras_cnt != '0);
  assign o_ras_top = o_ras_vld ? ras_mem[ras_top_idx] : '0;

endmodule

// File: tb/tb_exu_bju_seq.sv
// Self-checking bench for exu_bju_seq: directed vector table, multi-cycle corner cases
// and randomized ops checked against a behavioural model with a queue-based RAS.
module tb_exu_bju_seq;

  localparam int XLEN      = 32;
  localparam int RAS_DEPTH = 4;

  logic            clk, rst_n, i_flush;
  logic            hs_ex4bj_val, hs_bj4ex_rdy;
  logic [3:0]      i_op;
  logic [XLEN-1:0] i_opn1, i_opn2, i_im, i_pc, i_mepc, i_mtvec;
  logic            i_rd_link, i_rs1_link, i_int_ena;
  logic            hs_bj4cal_val, hs_cal4bj_rdy;
  logic [2:0]      o_cal_op;
  logic [XLEN:0]   o_cal_opn1, o_cal_opn2;
  logic [XLEN-1:0] i_cal_res;
  logic            hs_bj4wb_val, hs_wb4bj_rdy;
  logic [XLEN-1:0] o_res, o_pc, o_ras_top;
  logic            o_setpc, o_misalign, o_mret, o_ras_vld;

  exu_bju_seq #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .hs_ex4bj_val(hs_ex4bj_val), .hs_bj4ex_rdy(hs_bj4ex_rdy),
    .i_op(i_op), .i_opn1(i_opn1), .i_opn2(i_opn2), .i_im(i_im), .i_pc(i_pc),
    .i_rd_link(i_rd_link), .i_rs1_link(i_rs1_link), .i_int_ena(i_int_ena),
    .i_mepc(i_mepc), .i_mtvec(i_mtvec),
    .hs_bj4cal_val(hs_bj4cal_val), .hs_cal4bj_rdy(hs_cal4bj_rdy),
    .o_cal_op(o_cal_op), .o_cal_opn1(o_cal_opn1), .o_cal_opn2(o_cal_opn2),
    .i_cal_res(i_cal_res),
    .hs_bj4wb_val(hs_bj4wb_val), .hs_wb4bj_rdy(hs_wb4bj_rdy),
    .o_res(o_res), .o_setpc(o_setpc), .o_pc(o_pc), .o_misalign(o_misalign),
    .o_mret(o_mret), .o_ras_top(o_ras_top), .o_ras_vld(o_ras_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, im, pc, mepc, mtvec;
    logic        rd_link, rs1_link, int_ena;
    logic        exp_setpc;
    logic [31:0] exp_pc, exp_res;
    logic        exp_mret;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] ras_m[$];
  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, b, im, pc,
                              input logic rd, rs1, intr, input logic [31:0] mepc, mtvec,
                              input logic esetpc, input logic [31:0] epc, eres, input logic emret);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.im = im; v.pc = pc;
    v.rd_link = rd; v.rs1_link = rs1; v.int_ena = intr; v.mepc = mepc; v.mtvec = mtvec;
    v.exp_setpc = esetpc; v.exp_pc = epc; v.exp_res = eres; v.exp_mret = emret;
    return v;
  endfunction

  // Architectural reference: what a branch/jump of this kind should do
  function automatic vec_t predict(input vec_t v);
    vec_t r = v;
    r.exp_setpc = 1'b0; r.exp_pc = v.pc + v.im; r.exp_res = '0; r.exp_mret = 1'b0;
    if (v.int_ena) begin
      r.exp_setpc = 1'b1; r.exp_pc = v.mtvec;
      return r;
    end
    case (v.op)
      4'd0: r.exp_setpc = (v.a == v.b);
      4'd1: r.exp_setpc = (v.a != v.b);
      4'd2: r.exp_setpc = ($signed(v.a) <  $signed(v.b));
      4'd3: r.exp_setpc = ($signed(v.a) >= $signed(v.b));
      4'd4: r.exp_setpc = (v.a <  v.b);
      4'd5: r.exp_setpc = (v.a >= v.b);
      4'd6: begin r.exp_setpc = 1'b1; r.exp_res = v.pc + 32'd4; end
      4'd7: begin r.exp_setpc = 1'b1; r.exp_pc = (v.a + v.im) & 32'hFFFF_FFFE; r.exp_res = v.pc + 32'd4; end
      4'd8: r.exp_res = v.pc + v.im;
      4'd9: begin r.exp_setpc = 1'b1; r.exp_pc = v.mepc; r.exp_mret = 1'b1; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic rasPush(input logic [31:0] val);
    ras_m.push_back(val);
    if (ras_m.size() > RAS_DEPTH) void'(ras_m.pop_front());
  endtask

  task automatic rasModel(input vec_t v);
    logic [31:0] ret;
    ret = v.pc + 32'd4;
    if (v.int_ena) return;
    if (v.op == 4'd6 && v.rd_link) rasPush(ret);
    else if (v.op == 4'd7) begin
      if (v.rd_link && v.rs1_link) begin
        if (ras_m.size() == 0) rasPush(ret);
        else ras_m[ras_m.size()-1] = ret;
      end else if (v.rd_link) rasPush(ret);
      else if (v.rs1_link && ras_m.size() > 0) void'(ras_m.pop_back());
    end
  endtask

  task automatic checkRas(input string tag);
    checkOutput({tag, "_ras_vld"}, {31'd0, o_ras_vld}, {31'd0, ras_m.size() != 0});
    if (ras_m.size() != 0) checkOutput({tag, "_ras_top"}, o_ras_top, ras_m[ras_m.size()-1]);
  endtask

  // Shared calculator behaviour as seen from the unit
  function automatic logic [31:0] calc(input logic [2:0] op, input logic [32:0] a, b);
    logic [32:0] s;
    if (op == 3'b100) begin s = a + b; return s[31:0]; end
    if (op == 3'b010) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    if (op == 3'b001) begin s = a ^ b; return s[31:0]; end
    return 32'hDEAD_BEEF;
  endfunction

  task automatic doReset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ras_m.delete();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v, input int cal_lat, input int wb_lat, input string tag);
    logic skip;
    int waited, cycles;
    skip = v.int_ena || (v.op >= 4'd9);
    checkOutput({tag, "_rdy"}, {31'd0, hs_bj4ex_rdy}, 32'd1);
    i_op = v.op; i_opn1 = v.a; i_opn2 = v.b; i_im = v.im; i_pc = v.pc;
    i_rd_link = v.rd_link; i_rs1_link = v.rs1_link; i_int_ena = v.int_ena;
    i_mepc = v.mepc; i_mtvec = v.mtvec; hs_ex4bj_val = 1'b1;
    @(negedge clk);
    hs_ex4bj_val = 1'b0;
    i_op = 4'($urandom); i_opn1 = $urandom; i_opn2 = $urandom; i_im = $urandom; i_pc = $urandom;
    i_rd_link = 1'($urandom); i_rs1_link = 1'($urandom); i_int_ena = 1'($urandom);
    i_mepc = $urandom; i_mtvec = $urandom;
    checkOutput({tag, "_path_cal"}, {31'd0, hs_bj4cal_val}, {31'd0, !skip});
    checkOutput({tag, "_path_wb"},  {31'd0, hs_bj4wb_val},  {31'd0, skip});
    waited = 0; cycles = 0;
    while (!hs_bj4wb_val && cycles < 64) begin
      if (hs_bj4cal_val) begin
        if (waited == cal_lat) begin
          hs_cal4bj_rdy = 1'b1;
          i_cal_res = calc(o_cal_op, o_cal_opn1, o_cal_opn2);
        end
        waited++;
      end
      @(negedge clk);
      hs_cal4bj_rdy = 1'b0;
      i_cal_res = $urandom;
      cycles++;
    end
    if (!hs_bj4wb_val) begin
      checkOutput({tag, "_wb_timeout"}, 32'd0, 32'd1);
      doReset();
      return;
    end
    for (int k = 0; k <= wb_lat; k++) begin
      checkOutput({tag, "_setpc"}, {31'd0, o_setpc}, {31'd0, v.exp_setpc});
      if (v.exp_setpc) checkOutput({tag, "_pc"}, o_pc, v.exp_pc);
      checkOutput({tag, "_res"}, o_res, v.exp_res);
      checkOutput({tag, "_misalign"}, {31'd0, o_misalign}, {31'd0, v.exp_setpc & v.exp_pc[1]});
      checkOutput({tag, "_mret_early"}, {31'd0, o_mret}, 32'd0);
      checkOutput({tag, "_wb_hold"}, {31'd0, hs_bj4wb_val}, 32'd1);
      if (k < wb_lat) @(negedge clk);
    end
    hs_wb4bj_rdy = 1'b1;
    #1;
    checkOutput({tag, "_mret"}, {31'd0, o_mret}, {31'd0, v.exp_mret});
    @(negedge clk);
    hs_wb4bj_rdy = 1'b0;
    checkOutput({tag, "_retire_wb"}, {31'd0, hs_bj4wb_val}, 32'd0);
    checkOutput({tag, "_retire_rdy"}, {31'd0, hs_bj4ex_rdy}, 32'd1);
    rasModel(v);
    checkRas(tag);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t v;
    rst_n = 1'b0; i_flush = 1'b0; hs_ex4bj_val = 1'b0; i_op = '0;
    i_opn1 = '0; i_opn2 = '0; i_im = '0; i_pc = '0; i_mepc = '0; i_mtvec = '0;
    i_rd_link = 1'b0; i_rs1_link = 1'b0; i_int_ena = 1'b0;
    hs_cal4bj_rdy = 1'b0; i_cal_res = '0; hs_wb4bj_rdy = 1'b0;

    vecs[0]  = mk(4'd0, 32'd5, 32'd5, 32'h20, 32'h100, 0, 0, 0, 0, 0, 1, 32'h120, 0, 0);
    vecs[1]  = mk(4'd4, 32'd1, 32'hFFFF_FFFF, 32'h40, 32'h200, 0, 0, 0, 0, 0, 1, 32'h240, 0, 0);
    vecs[2]  = mk(4'd2, 32'd1, 32'hFFFF_FFFF, 32'h40, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(4'd7, 32'h1001, 0, 32'd2, 32'h300, 1, 0, 0, 0, 0, 1, 32'h1002, 32'h304, 0);
    vecs[4]  = mk(4'd1, 32'd3, 32'd4, 32'h10, 32'h400, 0, 0, 1, 0, 32'h8000_0000, 1, 32'h8000_0000, 0, 0);
    vecs[5]  = mk(4'd9, 0, 0, 0, 32'h500, 0, 0, 0, 32'h1234, 0, 1, 32'h1234, 0, 1);
    vecs[6]  = mk(4'd8, 0, 0, 32'h5000, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 32'h6000, 0);
    vecs[7]  = mk(4'd6, 0, 0, 32'h20, 32'hFFFF_FFF0, 0, 0, 0, 0, 0, 1, 32'h10, 32'hFFFF_FFF4, 0);
    vecs[8]  = mk(4'd6, 0, 0, 32'd2, 32'h600, 0, 0, 0, 0, 0, 1, 32'h602, 32'h604, 0);
    vecs[9]  = mk(4'd12, 32'd7, 32'd7, 32'd4, 32'h700, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(4'd9, 0, 0, 0, 32'h800, 0, 0, 1, 32'h1234, 32'h40, 1, 32'h40, 0, 0);
    vecs[11] = mk(4'd5, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h900, 0, 0, 0, 0, 0, 1, 32'h908, 0, 0);
    vecs[12] = mk(4'd3, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h900, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(4'd6, 0, 0, 32'd4, 32'hA00, 1, 0, 1, 0, 32'h44, 1, 32'h44, 0, 0);

    #1;
    checkOutput("reset_rdy", {31'd0, hs_bj4ex_rdy}, 32'd1);
    checkOutput("reset_wb_val", {31'd0, hs_bj4wb_val}, 32'd0);
    checkOutput("reset_cal_val", {31'd0, hs_bj4cal_val}, 32'd0);
    checkOutput("reset_setpc", {31'd0, o_setpc}, 32'd0);
    checkOutput("reset_pc", o_pc, 32'd0);
    checkOutput("reset_res", o_res, 32'd0);
    checkOutput("reset_ras_vld", {31'd0, o_ras_vld}, 32'd0);
    checkOutput("reset_cal_op", {29'd0, o_cal_op}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      applyStimulus(vecs[i], (i == 0) ? 3 : (i % 3), i % 2, $sformatf("vec%0d", i));

    // Reset in the middle of a CAL clears everything, including the RAS
    v = predict(mk(4'd6, 0, 0, 32'h40, 32'h2000, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(v, 0, 0, "pre_rst");
    hs_ex4bj_val = 1'b1; i_op = 4'd6; i_pc = 32'h3000; i_rd_link = 1'b1; i_int_ena = 1'b0;
    @(negedge clk);
    hs_ex4bj_val = 1'b0;
    checkOutput("midrst_in_cal", {31'd0, hs_bj4cal_val}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rdy", {31'd0, hs_bj4ex_rdy}, 32'd1);
    checkOutput("midrst_cal_val", {31'd0, hs_bj4cal_val}, 32'd0);
    checkOutput("midrst_ras_vld", {31'd0, o_ras_vld}, 32'd0);
    checkOutput("midrst_ras_top", o_ras_top, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ras_m.delete();
    @(negedge clk);

    // Five nested calls overflow a 4-deep RAS, five returns unwind it
    for (int k = 0; k < 5; k++) begin
      v = predict(mk(4'd6, 0, 0, 32'h100, 32'h1000 * (k + 1), 1, 0, 0, 0, 0, 0, 0, 0, 0));
      applyStimulus(v, k % 2, 0, $sformatf("call%0d", k));
    end
    for (int k = 0; k < 5; k++) begin
      v = predict(mk(4'd7, 32'h1000 * (5 - k) + 4, 0, 0, 32'h9000 + 32'h10 * k, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      applyStimulus(v, 1, 0, $sformatf("ret%0d", k));
    end
    checkOutput("ret_ras_empty", {31'd0, o_ras_vld}, 32'd0);

    // Flush during CAL with a same-cycle calculator response: op is dropped
    v = predict(mk(4'd6, 0, 0, 32'h40, 32'h4000, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(v, 0, 0, "pre_flush");
    hs_ex4bj_val = 1'b1; i_op = 4'd6; i_pc = 32'h5000; i_rd_link = 1'b1; i_int_ena = 1'b0;
    @(negedge clk);
    hs_ex4bj_val = 1'b0;
    checkOutput("flush_in_cal", {31'd0, hs_bj4cal_val}, 32'd1);
    i_flush = 1'b1; hs_cal4bj_rdy = 1'b1; i_cal_res = 32'h5004;
    @(negedge clk);
    i_flush = 1'b0; hs_cal4bj_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("flush_rdy", {31'd0, hs_bj4ex_rdy}, 32'd1);
      checkOutput("flush_no_wb", {31'd0, hs_bj4wb_val}, 32'd0);
      checkOutput("flush_no_cal", {31'd0, hs_bj4cal_val}, 32'd0);
      @(negedge clk);
    end
    checkRas("flush");

    // Flush in RESP beats the writeback handshake: no mret pulse
    hs_ex4bj_val = 1'b1; i_op = 4'd9; i_mepc = 32'h700; i_int_ena = 1'b0;
    @(negedge clk);
    hs_ex4bj_val = 1'b0;
    checkOutput("flresp_wb", {31'd0, hs_bj4wb_val}, 32'd1);
    i_flush = 1'b1; hs_wb4bj_rdy = 1'b1;
    #1;
    checkOutput("flresp_mret", {31'd0, o_mret}, 32'd0);
    @(negedge clk);
    i_flush = 1'b0; hs_wb4bj_rdy = 1'b0;
    checkOutput("flresp_wb_gone", {31'd0, hs_bj4wb_val}, 32'd0);
    checkOutput("flresp_rdy", {31'd0, hs_bj4ex_rdy}, 32'd1);

    // Randomized ops against the reference model
    for (int n = 0; n < 150; n++) begin
      v.op = 4'($urandom_range(0, 15));
      v.a = $urandom;
      v.b = ($urandom_range(0, 3) == 0) ? v.a : $urandom;
      if ($urandom_range(0, 3) == 0) v.b = {~v.a[31], v.a[30:0]};
      v.im = $urandom_range(0, 4095) << 1;
      v.pc = $urandom & 32'hFFFF_FFFC;
      v.mepc = $urandom; v.mtvec = $urandom;
      v.rd_link = 1'($urandom); v.rs1_link = 1'($urandom);
      v.int_ena = ($urandom_range(0, 7) == 0);
      v = predict(v);
      applyStimulus(v, $urandom_range(0, 3), $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
